// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//
// General-purpose register file for the RISC-V core. 32 x 32-bit registers,
// one write port fed by the MEM/WB pipeline register and two combinational
// read ports serving the decode stage. A read of the index being written in
// the same cycle returns the incoming write data (WB->ID bypass). Register
// x0 has no storage, always reads as zero and ignores writes.
//
// Ports:
//   clk     in   core clock; writes land on the rising edge
//   rst     in   asynchronous, active-low reset; clears x1..x31 and forces
//                both read ports to zero while low
//   we      in   write enable (MEM/WB wb_wreg)
//   waddr   in   write index  (MEM/WB wb_wd)
//   wdata   in   write data   (MEM/WB wb_wdata)
//   re1     in   read enable, port 1
//   raddr1  in   read index, port 1
//   rdata1  out  read data, port 1
//   re2     in   read enable, port 2
//   raddr2  in   read index, port 2
//   rdata2  out  read data, port 2
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  // Storage for x1..x(NREGS-1); x0 is implied zero and has no flops.
  logic [DATA_W-1:0] regs_q [1:NREGS-1];
  logic [DATA_W-1:0] regs_d [1:NREGS-1];

  // Next-state for the storage array. A write to x0 matches no entry, so it
  // falls through as a no-op without a dedicated check.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    regs_d = regs_q;
    if (we) begin
      for (int i = 1; i < NREGS; i++) begin
        if (waddr == ADDR_W'(i)) regs_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the array is cleared by the reset branch because software
      // relies on x1..x31 starting at zero; a plain RAM macro would not
      // offer this, so the storage stays as flops.
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of evaluation order.
      regs_q <= regs_d;
    end
  end

  // Storage lookup through a compare-and-select loop; index 0 selects
  // nothing and returns zero.
  function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (addr == ADDR_W'(i)) val = regs_q[i];
    end
    return val;
  endfunction

  // One read port. Priority: reset, x0, bypass, storage, disabled.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              re,
    input logic [ADDR_W-1:0] raddr
  );
    if (!rst)                          return '0;
    else if (raddr == '0)              return '0;
    else if (re && we && raddr == waddr) return wdata;
    else if (re)                       return lookup(raddr);
    else                               return '0;
  endfunction

  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

endmodule

// File: tb/tb_regfile.sv
// -----------------------------------------------------------------------------
// tb_regfile
//
// Self-checking bench for regfile: directed scenarios for reset, basic
// write/read, x0, bypass, read-enable gating and a full back-to-back sweep,
// followed by randomized traffic (including mid-cycle reset pulses) compared
// against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model [32];

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference read behaviour, straight from the priority rules.
  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
    if (!rst) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (re && we && a == waddr) return wdata;
    if (re) return model[a];
    return 32'h0;
  endfunction

  task automatic check_ports(input string tag);
    check({tag, "_p1"}, rdata1, exp_read(re1, raddr1));
    check({tag, "_p2"}, rdata2, exp_read(re2, raddr2));
  endtask

  task automatic clear_model();
    foreach (model[i]) model[i] = 32'h0;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2);
    we = w; waddr = wa; wdata = wd;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  // Advance one clock: the model commits the write at the rising edge, then
  // control returns at the following falling edge for the next stimulus.
  task automatic tick();
    @(posedge clk);
    if (rst && we && waddr != 5'd0) model[waddr] = wdata;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    clear_model();
    drive(1'b1, 5'd5, 32'hCAFE_F00D, 1'b1, 5'd5, 1'b1, 5'd5);
    @(negedge clk);
    #1;
    check("reset_hold_p1", rdata1, 32'h0);
    check("reset_hold_p2", rdata2, 32'h0);
    tick();
    #1;
    check("reset_ignores_write", rdata1, 32'h0);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    #1;
    check("post_reset_x5", rdata1, 32'h0);
    @(negedge clk);

    // Reset clear: write x5, then pulse reset between edges.
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    #1;
    check("x5_written", rdata1, 32'hDEAD_BEEF);
    rst = 1'b0;
    clear_model();
    #1;
    check("rst_async_out", rdata1, 32'h0);
    rst = 1'b1;
    #1;
    check("rst_async_clear", rdata1, 32'h0);
    tick();
    check("rst_clear_after_edge", rdata1, 32'h0);

    // Basic write/read on x7.
    drive(1'b0, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    check("pre_write_x7", rdata1, 32'h0);
    drive(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd7, 1'b0, 5'd7);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    check("basic_x7_p1", rdata1, 32'h1234_5678);
    check("basic_x7_p2", rdata2, 32'h1234_5678);

    // x0 hardwiring, same cycle and next.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    check("x0_same_cycle", rdata1, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("x0_next_cycle", rdata1, 32'h0);

    // Bypass on x3 over an older value.
    drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 1'b1, 5'd3);
    #1;
    check("bypass_p1", rdata1, 32'h22);
    check("bypass_p2", rdata2, 32'h22);
    tick();
    we = 1'b0;
    #1;
    check("bypass_after_p1", rdata1, 32'h22);
    check("bypass_after_p2", rdata2, 32'h22);

    // Read-enable gating on x9, without and with bypass.
    drive(1'b1, 5'd9, 32'hABCD, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b1, 5'd9);
    #1;
    check("gate_p1", rdata1, 32'h0);
    check("gate_p2", rdata2, 32'hABCD);
    drive(1'b1, 5'd9, 32'h5555, 1'b0, 5'd9, 1'b1, 5'd9);
    #1;
    check("gate_byp_p1", rdata1, 32'h0);
    check("gate_byp_p2", rdata2, 32'h5555);
    tick();

    // Back-to-back writes of every register, then a sweep on both ports.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      re1 = 1'b1; raddr1 = 5'(i);
      re2 = 1'b1; raddr2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_p1_x%0d", i), rdata1, 32'(i) * 32'h0101_0101);
      check($sformatf("sweep_p2_x%0d", 31 - i), rdata2, 32'(31 - i) * 32'h0101_0101);
    end
    @(negedge clk);

    // Randomized traffic against the model, with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) raddr1 = waddr;
      if ($urandom_range(0, 3) == 0) raddr2 = waddr;
      #1;
      check_ports($sformatf("rand%0d", n));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        clear_model();
        #1;
        check_ports($sformatf("rand%0d_rst", n));
        rst = 1'b1;
        #1;
        check_ports($sformatf("rand%0d_rel", n));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the RISC-V core: 32 registers of 32 bits, written by the write-back stage and read by the decode stage. It consumes the MEM/WB pipeline register outputs (destination address, write enable, write data) as its write port. It serves two operand read ports to ID, with same-cycle write-to-read bypass. Register x0 reads as zero and is never written.

## Interface
- `DATA_W`, default 32: register width (`RegBus`).
- `ADDR_W`, default 5: register index width (`RegAddrBus`).
- `NREGS`, default 32: register count, equal to 2**ADDR_W.

Ports:
- `clk`  input  1: core clock; all writes on rising edge.
- `rst`  input  1: reset. Asynchronous, active-low.
- `we`  input  1: write enable, driven from MEM/WB `wb_wreg`.
- `waddr`  input  ADDR_W: write index, from `wb_wd`.
- `wdata`  input  DATA_W: write data, from `wb_wdata`.
- `re1`  input  1: read enable, port 1.
- `raddr1`  input  ADDR_W: read index, port 1.
- `rdata1`  output  DATA_W: read data, port 1.
- `re2`  input  1: read enable, port 2.
- `raddr2`  input  ADDR_W: read index, port 2.
- `rdata2`  output  DATA_W: read data, port 2.

## Operation
- Storage: registers x1..x31 are flops. x0 has no storage.
- Reset (`rst`=0, asynchronous): x1..x31 clear to 0 immediately, without waiting for a clock edge. While reset is held:
  - writes are ignored;
  - `rdata1` and `rdata2` are 0.
- Write: on a rising `clk` edge with `rst`=1, `we`=1 and `waddr`≠0, register[`waddr`] takes `wdata`.
  - `we`=1 with `waddr`=0 is a no-op.
  - `we`=0 leaves all registers unchanged.
- Read, per port n, combinational. The first matching rule applies:
  1. `rst`=0 → 0.
  2. `raddrn`=0 → 0, regardless of `re` or `we`.
  3. `ren`=1, `we`=1 and `raddrn`=`waddr` → `wdata` (bypass).
  4. `ren`=1 → register[`raddrn`].
  5. `ren`=0 → 0.
- The two ports are independent. Both may read the same index, and both may bypass in the same cycle.
- Reset deassertion mid-operation: the first rising edge after `rst` rises accepts a write normally. Reads reflect cleared contents until that edge.

## Timing
- Write latency: 1 cycle. Data written at edge k is visible through storage after edge k.
- Bypass: zero-latency. A read of the address being written in the same cycle returns `wdata` before the edge. This lets WB→ID hazards resolve without a stall.
- Read path is purely combinational from `raddrn`, `ren`, `we`, `waddr`, `wdata` and `rst` to `rdatan`. There is no clock-to-read register.
- Reset-to-output: `rdata1` and `rdata2` go to 0 combinationally on `rst` falling. Register contents clear asynchronously at the same time.
- No back-pressure and no handshake: one write accepted per cycle, and reads are always available.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to x5, then pulse `rst` low between clock edges, release it, and read x5 on port 1 with `re1`=1.
  - Required: `rdata1`=0 during reset and after release. Contents clear without any clock edge.
- Basic write/read:
  - Stimulus: `we`=1, `waddr`=7, `wdata`=0x12345678 for one edge, then `we`=0. Read x7 on both ports.
  - Required: `rdata1`=`rdata2`=0x12345678. Before the write edge, with `we`=0, the read returns 0.
- x0 hardwiring:
  - Stimulus: `we`=1, `waddr`=0, `wdata`=0xFFFFFFFF. In the same cycle and in the next cycle, `raddr1`=0 with `re1`=1.
  - Required: `rdata1`=0 in both cycles. No bypass to x0.
- Bypass:
  - Stimulus: x3 holds 0x11. In a single cycle, `we`=1, `waddr`=3, `wdata`=0x22, `raddr1`=3, `raddr2`=3, `re1`=`re2`=1.
  - Required: both outputs read 0x22 before the edge and 0x22 after the edge with `we`=0.
- Read enable gating:
  - Stimulus: x9=0xABCD; `re1`=0 with `raddr1`=9, and `re2`=1 with `raddr2`=9.
  - Required: `rdata1`=0 and `rdata2`=0xABCD. Repeating the same check with bypass active on x9 gives the same gating.
- Back-to-back writes:
  - Stimulus: write x1..x31 with the value (index × 0x01010101) on consecutive edges, then sweep reads on both ports.
  - Required: every register returns its own value and x0 returns 0.
